// File: rtl/scie_issuer.sv
// Issues load/accumulate/read instructions to the SCIE unit and captures read results.
// Reads after a non-read issue may be delayed by READ_GAP idle cycles; results are held until consumed.
module scie_issuer #(
  parameter int LATENCY  = 1,
  parameter int READ_GAP = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_rs1_real,
  input  logic [15:0] cmd_rs1_imag,
  input  logic [31:0] cmd_rs2,
  output logic        scie_valid,
  output logic [31:0] scie_insn,
  output logic [15:0] scie_rs1_real,
  output logic [15:0] scie_rs1_imag,
  output logic [31:0] scie_rs2,
  input  logic [15:0] scie_rd_real,
  input  logic [15:0] scie_rd_imag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_real,
  output logic [15:0] rsp_imag
);

  localparam logic [1:0]  OP_LOAD    = 2'd0;
  localparam logic [1:0]  OP_ACC     = 2'd1;
  localparam logic [1:0]  OP_READ    = 2'd2;
  localparam logic [31:0] INSN_LOAD  = 32'h0000_000B;
  localparam logic [31:0] INSN_ACC   = 32'h0000_002B;
  localparam logic [31:0] INSN_READ  = 32'h0000_005B;
  localparam logic [2:0]  LAT_CNT    = 3'(LATENCY);
  localparam logic [2:0]  GAP_CNT    = 3'(READ_GAP);
  localparam logic        GAP_EN     = (READ_GAP > 0);

  typedef enum logic [1:0] {IDLE, GAP, WAIT, HOLD} state_t;

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  logic        nr_flag, nr_flag_nx;
  logic [2:0]  idle_cnt, idle_cnt_nx;
  logic [15:0] pend_real, pend_imag;
  logic [31:0] pend_rs2;

  logic        issue;
  logic [31:0] issue_insn;
  logic        issue_from_pend;
  logic        load_pend;
  logic        capture;
  logic        quiet;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      nr_flag  <= 1'b0;
      idle_cnt <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      nr_flag  <= nr_flag_nx;
      idle_cnt <= idle_cnt_nx;
    end
  end

  always_comb begin
    state_nx        = state;
    cnt_nx          = cnt;
    nr_flag_nx      = nr_flag;
    idle_cnt_nx     = idle_cnt;
    cmd_ready       = 1'b0;
    issue           = 1'b0;
    issue_insn      = INSN_READ;
    issue_from_pend = 1'b0;
    load_pend       = 1'b0;
    capture         = 1'b0;
    quiet           = 1'b0;

    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        // A quiet cycle has no issue on the bus and accepts nothing that issues.
        quiet     = !scie_valid;
        if (cmd_valid) begin
          case (cmd_op)
            OP_LOAD, OP_ACC: begin
              issue       = 1'b1;
              issue_insn  = (cmd_op == OP_LOAD) ? INSN_LOAD : INSN_ACC;
              nr_flag_nx  = GAP_EN;
              idle_cnt_nx = '0;
              quiet       = 1'b0;
            end
            OP_READ: begin
              quiet       = 1'b0;
              nr_flag_nx  = 1'b0;
              idle_cnt_nx = '0;
              if (GAP_EN && nr_flag) begin
                state_nx  = GAP;
                cnt_nx    = GAP_CNT;
                load_pend = 1'b1;
              end else begin
                issue    = 1'b1;
                state_nx = WAIT;
                cnt_nx   = LAT_CNT;
              end
            end
            default: ;
          endcase
        end
        if (quiet && nr_flag) begin
          if (idle_cnt + 3'd1 >= GAP_CNT) begin
            nr_flag_nx  = 1'b0;
            idle_cnt_nx = '0;
          end else begin
            idle_cnt_nx = idle_cnt + 3'd1;
          end
        end
      end
      GAP: begin
        if (cnt == 3'd1) begin
          issue           = 1'b1;
          issue_from_pend = 1'b1;
          state_nx        = WAIT;
          cnt_nx          = LAT_CNT;
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end
      WAIT: begin
        // WAIT starts in the issue cycle, so the last count lands LATENCY edges after issue.
        if (cnt == 3'd1) begin
          capture  = 1'b1;
          state_nx = HOLD;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end
      HOLD: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign rsp_valid = (state == HOLD);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scie_valid    <= 1'b0;
      scie_insn     <= '0;
      scie_rs1_real <= '0;
      scie_rs1_imag <= '0;
      scie_rs2      <= '0;
      pend_real     <= '0;
      pend_imag     <= '0;
      pend_rs2      <= '0;
      rsp_real      <= '0;
      rsp_imag      <= '0;
    end else begin
      scie_valid <= issue;
      if (issue) begin
        scie_insn     <= issue_insn;
        scie_rs1_real <= issue_from_pend ? pend_real : cmd_rs1_real;
        scie_rs1_imag <= issue_from_pend ? pend_imag : cmd_rs1_imag;
        scie_rs2      <= issue_from_pend ? pend_rs2  : cmd_rs2;
      end
      if (load_pend) begin
        pend_real <= cmd_rs1_real;
        pend_imag <= cmd_rs1_imag;
        pend_rs2  <= cmd_rs2;
      end
      if (capture) begin
        rsp_real <= scie_rd_real;
        rsp_imag <= scie_rd_imag;
      end
    end
  end

endmodule

// File: doc/scie_issuer.md
SCIE_ISSUER -- requirements
Module: scie_issuer

Interface
REQ-001 Parameter: LATENCY, default 1, number of cycles from read-instruction issue to valid scie_rd_* sample (range 1-7).
REQ-002 Parameter: READ_GAP, default 1, number of idle cycles inserted before a read that follows a non-read issue (range 0-3).
REQ-003 Ports, one per line (name, direction, width, meaning):
- clock  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when high with cmd_valid.
- cmd_op  input  2  0=load (insn 0x0000000B), 1=accumulate (0x0000002B), 2=read (0x0000005B), 3=NOP.
- cmd_rs1_real  input  16  signed operand, real part.
- cmd_rs1_imag  input  16  signed operand, imaginary part.
- cmd_rs2  input  32  second operand.
- scie_valid  output  1  instruction valid to the SCIE unit.
- scie_insn  output  32  instruction word.
- scie_rs1_real  output  16  signed.
- scie_rs1_imag  output  16  signed.
- scie_rs2  output  32  second operand.
- scie_rd_real  input  16  signed result from the SCIE unit.
- scie_rd_imag  input  16  signed result from the SCIE unit.
- rsp_valid  output  1  result held.
- rsp_ready  input  1  result consumed when high with rsp_valid.
- rsp_real  output  16  signed captured result.
- rsp_imag  output  16  signed captured result.

Function
REQ-004 The FSM SHALL have four states: IDLE, GAP, WAIT, HOLD.
REQ-005 In IDLE, cmd_ready SHALL be 1; cmd_ready SHALL be 0 in GAP, WAIT and HOLD.
REQ-006 On acceptance of op 0/1, the block SHALL register scie_valid=1, the matching scie_insn and operands for exactly the next cycle, then remain in IDLE (back-to-back issue allowed).
REQ-007 On acceptance of op 3, the block SHALL issue nothing and remain in IDLE.
REQ-008 On acceptance of op 2 with READ_GAP>0 and previous issue was op 0/1, the block SHALL enter GAP for READ_GAP cycles with scie_valid=0, then issue the read.
REQ-009 On read issue (scie_valid=1, scie_insn=0x5B), the FSM SHALL enter WAIT and count LATENCY cycles.
REQ-010 On the final WAIT cycle, rsp_real/rsp_imag SHALL capture scie_rd_real/scie_rd_imag and the FSM SHALL enter HOLD with rsp_valid=1.
REQ-011 In HOLD, rsp_* SHALL be stable until rsp_ready=1; then rsp_valid SHALL drop the next cycle and the FSM SHALL return to IDLE.
REQ-012 The "previous issue was non-read" flag SHALL clear after a read and after READ_GAP idle IDLE cycles without issue.
REQ-013 Outside an issue cycle scie_valid SHALL be 0 and scie_insn, scie_rs* SHALL hold their last values.
REQ-014 Results SHALL be passed without width change, sign extension or saturation.
REQ-015 rsp_ready asserted while rsp_valid=0 SHALL have no effect.

Reset
REQ-016 While reset=0, the FSM SHALL be IDLE, counters zero, flag cleared, scie_valid=0, scie_insn=0, scie_rs*=0, rsp_valid=0, rsp_real=0, rsp_imag=0.
REQ-017 Reset asserted mid-GAP, WAIT or HOLD SHALL abort the operation with no response emitted; first cmd after release SHALL be accepted in IDLE.

Verification
REQ-018 Load (rs1=12-35j, rs2=0) then accumulate (35-5j, rs2=1) back-to-back -> scie_valid high two consecutive cycles, insn 0x0B then 0x2B, cmd_ready continuously 1.
REQ-019 Accumulate then read, READ_GAP=1, LATENCY=1, stub drives rd=1530-1040j -> one idle cycle, read issue, rsp_valid next cycle with rsp=1530/-1040.
REQ-020 Read with rsp_ready held 0 for 5 cycles while stub rd changes -> rsp stays 1530/-1040, cmd_ready 0, no scie_valid; release -> IDLE next cycle.
REQ-021 Read after read (no intervening op 0/1), READ_GAP=2 -> no GAP cycles inserted; second result 1660/301 returned in order.
REQ-022 NOP command -> accepted, scie_valid stays 0, no response.
REQ-023 Reset pulled low during WAIT (LATENCY=3) -> all outputs zero immediately, no rsp_valid after release.
